ntt_sdf_reorder: RTL and testbench

- Output reorder buffer that sits directly downstream of the last ntt_sdf_stage in the SDF NTT pipeline.
- Consumes the stage's serial stream (stage_out, qualified by finish), which is in bit-reversed order, and re-emits each N-word frame in natural order.
- Uses ping-pong banks so input streams continuously at 1 word/cycle while the previous frame drains through a ready/valid output.

---
 rtl/ntt_sdf_pkg.sv | 24 ++
 rtl/ntt_pingpong_ram.sv | 57 +++++
 rtl/ntt_sdf_reorder.sv | 167 ++++++++++++++++
 tb/tb_ntt_sdf_reorder.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_sdf_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ntt_sdf_pkg                                                          |
// | Shared types and helpers for the SDF NTT output reorder path.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package ntt_sdf_pkg;

  typedef enum logic {
    BANK_EMPTY = 1'b0,
    BANK_FULL  = 1'b1
  } bank_state_e;

  // Reverse the low 'width' bits of 'value'; bits above 'width' return as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] value, input int width);
    logic [31:0] rev;
    for (int i = 0; i < 32; i++) begin
      rev[i] = value[31-i];
    end
    return rev >> (32 - width);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ntt_pingpong_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ntt_pingpong_ram                                                     |
// | Simple dual-port RAM with enabled, resettable registered read port.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ntt_pingpong_ram #(
  parameter int WIDTH = 64,
  parameter int AW    = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  localparam int c_DEPTH = 1 << AW;

  logic [WIDTH-1:0] w_rd_word;
  logic [WIDTH-1:0] r_rd_data;

  // Two banks of 128+ words go to block RAM; smaller frames stay in LUTs.
  generate
    if (AW >= 8) begin : g_bram
      (* ram_style = "block" *) logic [WIDTH-1:0] mem [c_DEPTH];
      always_ff @(posedge clk) begin
        if (i_wr_en) mem[i_wr_addr] <= i_wr_data;
      end
      assign w_rd_word = mem[i_rd_addr];
    end else begin : g_lutram
      (* ram_style = "distributed" *) logic [WIDTH-1:0] mem [c_DEPTH];
      always_ff @(posedge clk) begin
        if (i_wr_en) mem[i_wr_addr] <= i_wr_data;
      end
      assign w_rd_word = mem[i_rd_addr];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_data <= '0;
    end else if (clear) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= w_rd_word;
    end
  end

  assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/ntt_sdf_reorder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ntt_sdf_reorder                                                      |
// | Ping-pong bit-reversed to natural order buffer behind the last SDF   |
// | stage. Optional macro NTT_REORDER_BYPASS_EN adds a per-frame bypass. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ntt_sdf_reorder #(
  parameter int LOGQ = 64,
  parameter int LOGN = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            in_valid,
  input  logic [LOGQ-1:0] in_data,
`ifdef NTT_REORDER_BYPASS_EN
  input  logic            bypass,
`endif
  output logic            out_valid,
  input  logic            out_ready,
  output logic [LOGQ-1:0] out_data,
  output logic            out_first,
  output logic            out_last,
  output logic            overflow
);

  import ntt_sdf_pkg::*;

  localparam logic [LOGN-1:0] c_CNT_MAX = '1;
  localparam logic [LOGN-1:0] c_CNT_ONE = LOGN'(1);

  bank_state_e     r_bank_state [2];
  logic            r_wbank;
  logic            r_rbank;
  logic [LOGN-1:0] r_wcnt;
  logic [LOGN-1:0] r_rcnt;
  logic            r_out_valid;
  logic            r_out_first;
  logic            r_out_last;
  logic            r_overflow;

  logic            w_wbank_empty;
  logic            w_rbank_full;
  logic            w_wr_en;
  logic            w_drop;
  logic            w_wr_done;
  logic            w_advance;
  logic            w_rd_en;
  logic            w_rd_done;
  logic [LOGN-1:0] w_waddr;
  logic [LOGN-1:0] w_waddr_rev;

  assign w_wbank_empty = (r_bank_state[r_wbank] == BANK_EMPTY);
  assign w_rbank_full  = (r_bank_state[r_rbank] == BANK_FULL);
  assign w_wr_en       = in_valid && w_wbank_empty;
  assign w_drop        = in_valid && !w_wbank_empty;
  assign w_wr_done     = w_wr_en && (r_wcnt == c_CNT_MAX);
  assign w_advance     = !r_out_valid || out_ready;
  assign w_rd_en       = w_advance && w_rbank_full;
  assign w_rd_done     = w_rd_en && (r_rcnt == c_CNT_MAX);
  assign w_waddr_rev   = LOGN'(bitrev(32'(r_wcnt), LOGN));

`ifdef NTT_REORDER_BYPASS_EN
  logic [1:0] r_bypass;
  logic       w_bypass_cur;

  // Word 0 lands at address 0 either way, so the live pin only matters there.
  assign w_bypass_cur = (r_wcnt == '0) ? bypass : r_bypass[r_wbank];
  assign w_waddr      = w_bypass_cur ? r_wcnt : w_waddr_rev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bypass <= '0;
    end else if (clear) begin
      r_bypass <= '0;
    end else if (w_wr_en && (r_wcnt == '0)) begin
      r_bypass[r_wbank] <= bypass;
    end
  end
`else
  assign w_waddr = w_waddr_rev;
`endif

  // Write side: pointer, counter and sticky drop flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wbank    <= 1'b0;
      r_wcnt     <= '0;
      r_overflow <= 1'b0;
    end else if (clear) begin
      r_wbank    <= 1'b0;
      r_wcnt     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_wcnt <= r_wcnt + c_CNT_ONE;
        if (w_wr_done) r_wbank <= ~r_wbank;
      end
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // Writer only fills EMPTY banks and reader only drains FULL ones, so the
  // two updates below can never target the same bank in one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bank_state[0] <= BANK_EMPTY;
      r_bank_state[1] <= BANK_EMPTY;
    end else if (clear) begin
      r_bank_state[0] <= BANK_EMPTY;
      r_bank_state[1] <= BANK_EMPTY;
    end else begin
      if (w_wr_done) r_bank_state[r_wbank] <= BANK_FULL;
      if (w_rd_done) r_bank_state[r_rbank] <= BANK_EMPTY;
    end
  end

  // Read side: output register stage shares the advance enable with the RAM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rbank     <= 1'b0;
      r_rcnt      <= '0;
      r_out_valid <= 1'b0;
      r_out_first <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (clear) begin
      r_rbank     <= 1'b0;
      r_rcnt      <= '0;
      r_out_valid <= 1'b0;
      r_out_first <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (w_advance) begin
      if (w_rbank_full) begin
        r_out_valid <= 1'b1;
        r_out_first <= (r_rcnt == '0);
        r_out_last  <= (r_rcnt == c_CNT_MAX);
        r_rcnt      <= r_rcnt + c_CNT_ONE;
        if (w_rd_done) r_rbank <= ~r_rbank;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  ntt_pingpong_ram #(
    .WIDTH (LOGQ),
    .AW    (LOGN + 1)
  ) u_ram (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .i_wr_en   (w_wr_en),
    .i_wr_addr ({r_wbank, w_waddr}),
    .i_wr_data (in_data),
    .i_rd_en   (w_rd_en),
    .i_rd_addr ({r_rbank, r_rcnt}),
    .o_rd_data (out_data)
  );

  assign out_valid = r_out_valid;
  assign out_first = r_out_first;
  assign out_last  = r_out_last;
  assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ntt_sdf_reorder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ntt_sdf_reorder                                                   |
// | Directed self-checking bench for ntt_sdf_reorder at N = 8.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_ntt_sdf_reorder;

  localparam int LOGQ = 16;
  localparam int LOGN = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            clear;
  logic            in_valid;
  logic [LOGQ-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [LOGQ-1:0] out_data;
  logic            out_first;
  logic            out_last;
  logic            overflow;
`ifdef NTT_REORDER_BYPASS_EN
  logic            bypass;
`endif

  int checks = 0;
  int errors = 0;
  int rv [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  always #5 clk = ~clk;

  ntt_sdf_reorder #(
    .LOGQ (LOGQ),
    .LOGN (LOGN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_data   (in_data),
`ifdef NTT_REORDER_BYPASS_EN
    .bypass    (bypass),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_first (out_first),
    .out_last  (out_last),
    .overflow  (overflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer n consecutive words base, base+1, ...; bymask bit f sets bypass for frame f.
  task automatic drive(input int base, input int n, input logic [3:0] bymask);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = LOGQ'(base + i);
`ifdef NTT_REORDER_BYPASS_EN
      bypass   = bymask[i/8];
`else
      if (bymask[i/8]) in_data = LOGQ'(base + i);
`endif
      tick();
    end
    in_valid = 1'b0;
  endtask

  // Consume nfr frames; natmask bit f means frame f comes out in natural order.
  task automatic drain(input int base, input int nfr, input bit alt, input logic [3:0] natmask);
    int   idx    = 0;
    int   budget = 300;
    bit   ph     = 1'b1;
    int   f;
    int   j;
    logic [LOGQ-1:0] e;
    while (idx < nfr * 8 && budget > 0) begin
      out_ready = alt ? ph : 1'b1;
      ph = !ph;
      if (out_valid) begin
        f = idx / 8;
        j = idx % 8;
        e = LOGQ'(base + f * 8 + (natmask[f] ? j : rv[j]));
        chk("out_data", 64'(out_data), 64'(e));
        chk("out_first", 64'(out_first), 64'(j == 0));
        chk("out_last", 64'(out_last), 64'(j == 7));
        if (out_ready) idx++;
      end else if (idx > 0) begin
        chk("no_gap_valid", 64'(out_valid), 64'd1);
      end
      tick();
      budget--;
    end
    if (idx < nfr * 8) chk("drain_timeout", 64'(idx), 64'(nfr * 8));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
`ifdef NTT_REORDER_BYPASS_EN
    bypass    = 1'b0;
`endif
    repeat (3) tick();

    // Reset state
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_first", 64'(out_first), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    rst = 1'b1;
    tick();

    // Test 1: single frame, latency and reorder
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = LOGQ'(i);
      tick();
    end
    in_valid = 1'b0;
    chk("t1_valid_before_latency", 64'(out_valid), 64'd0);
    tick();
    chk("t1_valid_at_latency", 64'(out_valid), 64'd1);
    drain(0, 1, 1'b0, 4'b0000);
    chk("t1_valid_after", 64'(out_valid), 64'd0);

    // Test 2: two back-to-back frames, no bubble
    fork
      drive(0, 16, 4'b0000);
      drain(0, 2, 1'b0, 4'b0000);
    join
    chk("t2_valid_after", 64'(out_valid), 64'd0);
    chk("t2_overflow", 64'(overflow), 64'd0);

    // Test 4: alternating out_ready during drain
    fork
      drive(0, 8, 4'b0000);
      drain(0, 1, 1'b1, 4'b0000);
    join
    chk("t4_valid_after", 64'(out_valid), 64'd0);

    // Test 3: stalled output, third frame dropped
    out_ready = 1'b0;
    drive(0, 24, 4'b0000);
    chk("t3_overflow", 64'(overflow), 64'd1);
    drain(0, 2, 1'b0, 4'b0000);
    chk("t3_valid_after", 64'(out_valid), 64'd0);
    chk("t3_overflow_sticky", 64'(overflow), 64'd1);

    // Test 5a: asynchronous reset mid-cycle
    out_ready = 1'b0;
    drive(40, 21, 4'b0000);
    chk("t5a_pre_valid", 64'(out_valid), 64'd1);
    chk("t5a_pre_data", 64'(out_data), 64'd40);
    #2;
    rst = 1'b0;
    #1;
    chk("t5a_valid", 64'(out_valid), 64'd0);
    chk("t5a_overflow", 64'(overflow), 64'd0);
    chk("t5a_first", 64'(out_first), 64'd0);
    chk("t5a_data", 64'(out_data), 64'd0);
    #1;
    rst = 1'b1;
    tick();
    fork
      drive(0, 8, 4'b0000);
      drain(0, 1, 1'b0, 4'b0000);
    join

    // Test 5b: synchronous clear with a partial frame in flight
    out_ready = 1'b0;
    drive(40, 13, 4'b0000);
    chk("t5b_pre_valid", 64'(out_valid), 64'd1);
    chk("t5b_pre_data", 64'(out_data), 64'd40);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t5b_valid", 64'(out_valid), 64'd0);
    chk("t5b_data", 64'(out_data), 64'd0);
    chk("t5b_first", 64'(out_first), 64'd0);
    chk("t5b_overflow", 64'(overflow), 64'd0);
    fork
      drive(0, 8, 4'b0000);
      drain(0, 1, 1'b0, 4'b0000);
    join
    chk("t5b_valid_after", 64'(out_valid), 64'd0);

`ifdef NTT_REORDER_BYPASS_EN
    // Test 6: bypassed frame followed by a reordered frame
    fork
      drive(0, 16, 4'b0001);
      drain(0, 2, 1'b0, 4'b0001);
    join
    chk("t6_valid_after", 64'(out_valid), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
